// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: fetches two 4x4 8-bit matrices (A, B) from word memory
// and packs each into a 128-bit column-major vector for dot_product.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             load request (sampled only in IDLE)
//   i_base_a, i_base_b  word addresses of A and B
//   o_mem_rd_en         read strobe
//   o_mem_addr          read word address
//   i_mem_rd_data       read data, valid one cycle after o_mem_rd_en
//   o_a_out, o_b_out    packed operands (element 0 in the MSB byte)
//   o_valid_out         operands complete and stable
//   i_ready_in          consumer accepts operands
//   o_busy              high outside IDLE
//   o_done              one-cycle pulse after the handshake
//
// Build option: define LOADER_TRANSPOSE_B_EN when B is stored row-major in
// memory; B is then transposed while packing so o_b_out stays column-major.
module matrix_operand_loader #(
    parameter int WIDTH_V    = 128,
    parameter int BITS_INDEX = 8,
    parameter int ADDR_W     = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_base_a,
    input  logic [ADDR_W-1:0]   i_base_b,
    output logic                o_mem_rd_en,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic [31:0]         i_mem_rd_data,
    output logic [WIDTH_V-1:0]  o_a_out,
    output logic [WIDTH_V-1:0]  o_b_out,
    output logic                o_valid_out,
    input  logic                i_ready_in,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;       // index of the read issued this cycle
    logic [ADDR_W-1:0] r_base_b;
    logic              r_pend;      // a read response is on i_mem_rd_data
    logic [2:0]        r_pend_idx;  // which of the 8 words it is (bit 2 = B)

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_base_b    <= '0;
            r_pend      <= 1'b0;
            r_pend_idx  <= '0;
            o_mem_rd_en <= 1'b0;
            o_mem_addr  <= '0;
            o_a_out     <= '0;
            o_b_out     <= '0;
            o_valid_out <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            r_pend     <= o_mem_rd_en;
            r_pend_idx <= r_cnt;

            // Write the returning word into its four byte lanes only.
            if (r_pend) begin
                for (int w = 0; w < 4; w++) begin
                    if (r_pend_idx[1:0] == w[1:0]) begin
                        for (int i = 0; i < 4; i++) begin
                            if (!r_pend_idx[2]) begin
                                o_a_out[WIDTH_V-1-BITS_INDEX*(4*w+i) -: BITS_INDEX]
                                    <= i_mem_rd_data[BITS_INDEX*i +: BITS_INDEX];
                            end else begin
`ifdef LOADER_TRANSPOSE_B_EN
                                // row-major element (row w, col i) -> k = i*4 + w
                                o_b_out[WIDTH_V-1-BITS_INDEX*(4*i+w) -: BITS_INDEX]
                                    <= i_mem_rd_data[BITS_INDEX*i +: BITS_INDEX];
`else
                                o_b_out[WIDTH_V-1-BITS_INDEX*(4*w+i) -: BITS_INDEX]
                                    <= i_mem_rd_data[BITS_INDEX*i +: BITS_INDEX];
`endif
                            end
                        end
                    end
                end
            end

            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_FETCH;
                        r_cnt       <= '0;
                        r_base_b    <= i_base_b;
                        o_mem_addr  <= i_base_a;
                        o_mem_rd_en <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        o_mem_rd_en <= 1'b0;
                        r_state     <= S_DRAIN;
                    end else if (r_cnt == 3'd3) begin
                        o_mem_addr <= r_base_b;
                    end else begin
                        o_mem_addr <= o_mem_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // last word is captured on this same edge
                    o_valid_out <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (o_valid_out && i_ready_in) begin
                        o_valid_out <= 1'b0;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
